spi_master_gen: RTL and testbench

Parametrised SPI master for the AES datapath's serial link. It is the generalised successor of the fixed 8-bit `master`. Data width, clock divider, chip-select count and bit order are configurable. CPOL/CPHA mode is selected per transfer, and a start/busy/done handshake is provided. It sits between the AES core's byte/word staging logic and the external SPI slave pins. It generates its own serial clock from the system clock.

---
 rtl/spi_master_gen.sv | 153 +++++++++++++++
 tb/tb_spi_master_gen.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_gen.sv
// Parametrised SPI master: configurable width, SCK divider, chip-select count and bit order,
// with CPOL/CPHA latched per transfer and a start/busy/done handshake.
module spi_master_gen #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 2,
  parameter int NUM_CS     = 1,
  parameter int LSB_FIRST  = 0,
  localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                  sclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [CS_W-1:0]       cs_sel,
  input  logic [DATA_WIDTH-1:0] MDS,
  input  logic                  MISO,
  output logic                  MOSI,
  output logic                  SCK,
  output logic [NUM_CS-1:0]     CS_n,
  output logic [DATA_WIDTH-1:0] MDO,
  output logic                  busy,
  output logic                  done
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HC_W  = $clog2(2 * DATA_WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  logic [1:0]            state;
  logic [DIV_W-1:0]      div_cnt;
  logic [HC_W-1:0]       half_cnt;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [DATA_WIDTH-1:0] rx_sr;
  logic                  cpol_r;
  logic                  cpha_r;

  logic tick;
  logic last_half;
  logic sample_edge;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_tx(input logic [DATA_WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? {1'b0, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_rx(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    return (LSB_FIRST != 0) ? {b, w[DATA_WIDTH-1:1]} : {w[DATA_WIDTH-2:0], b};
  endfunction

  // An out-of-range index matches no line, so the transfer runs with every CS_n high.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
    logic [NUM_CS-1:0] v;
    v = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (sel == CS_W'(i)) v[i] = 1'b0;
    end
    return v;
  endfunction

  assign tick      = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_half = (half_cnt == HC_W'(2 * DATA_WIDTH - 1));
  // Even half_cnt ends in a leading edge; cpha=0 samples there, cpha=1 on the trailing one.
  assign sample_edge = ~half_cnt[0] ^ cpha_r;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      half_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      SCK      <= 1'b0;
      MOSI     <= 1'b0;
      CS_n     <= '1;
      MDO      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          SCK  <= cpol;
          MOSI <= 1'b0;
          if (start) begin
            cpol_r   <= cpol;
            cpha_r   <= cpha;
            CS_n     <= cs_decode(cs_sel);
            rx_sr    <= '0;
            // cpha=0 presents the first bit now; cpha=1 drives it on the first leading edge.
            tx_sr    <= cpha ? MDS : shift_tx(MDS);
            MOSI     <= cpha ? 1'b0 : first_bit(MDS);
            busy     <= 1'b1;
            div_cnt  <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (tick) begin
            div_cnt  <= '0;
            half_cnt <= '0;
            state    <= S_XFER;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_XFER: begin
          if (tick) begin
            div_cnt <= '0;
            SCK     <= ~SCK;
            if (sample_edge) begin
              rx_sr <= shift_rx(rx_sr, MISO);
            end else if (cpha_r || !last_half) begin
              MOSI  <= first_bit(tx_sr);
              tx_sr <= shift_tx(tx_sr);
            end
            if (last_half) state <= S_HOLD;
            else           half_cnt <= half_cnt + HC_W'(1);
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (tick) begin
            div_cnt <= '0;
            CS_n    <= '1;
            MDO     <= rx_sr;
            done    <= 1'b1;
            busy    <= 1'b0;
            MOSI    <= 1'b0;
            SCK     <= cpol;
            state   <= S_IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_gen.sv
// Scoreboard bench for spi_master_gen: two configurations (W8/DIV2/3 CS/MSB and W16/DIV1/1 CS/LSB),
// stimulus pushes expected transfers, per-DUT monitors pop and compare on each done pulse.
`timescale 1ns/1ps
module tb_spi_master_gen;

  typedef struct {
    logic [15:0] mdo;
    logic [15:0] mosi;
    logic [2:0]  csn;
    logic        cpol;
    logic        cpha;
    int          cycles;
    int          rises;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic       start_a, cpol_a, cpha_a, miso_a, mosi_a, sck_a, busy_a, done_a;
  logic [1:0] sel_a;
  logic [7:0] mds_a, mdo_a;
  logic [2:0] csn_a;

  logic        start_b, cpol_b, cpha_b, miso_b, mosi_b, sck_b, busy_b, done_b;
  logic [0:0]  sel_b, csn_b;
  logic [15:0] mds_b, mdo_b;

  int n_checks = 0;
  int n_fail   = 0;
  exp_t q_a[$];
  exp_t q_b[$];

  logic       loop_a;
  logic [7:0] slave_a;
  int         edges_a;

  spi_master_gen #(.DATA_WIDTH(8), .CLK_DIV(2), .NUM_CS(3), .LSB_FIRST(0)) dut_a (
    .sclk(clk), .reset(reset), .start(start_a), .cpol(cpol_a), .cpha(cpha_a),
    .cs_sel(sel_a), .MDS(mds_a), .MISO(miso_a), .MOSI(mosi_a), .SCK(sck_a),
    .CS_n(csn_a), .MDO(mdo_a), .busy(busy_a), .done(done_a));

  spi_master_gen #(.DATA_WIDTH(16), .CLK_DIV(1), .NUM_CS(1), .LSB_FIRST(1)) dut_b (
    .sclk(clk), .reset(reset), .start(start_b), .cpol(cpol_b), .cpha(cpha_b),
    .cs_sel(sel_b), .MDS(mds_b), .MISO(miso_b), .MOSI(mosi_b), .SCK(sck_b),
    .CS_n(csn_b), .MDO(mdo_b), .busy(busy_b), .done(done_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave for DUT A, MSB first: cpha=0 presents bit j before leading edge j, cpha=1 after it.
  function automatic logic slave_bit(input int e, input logic pha, input logic [7:0] w);
    int idx;
    idx = pha ? (e - 1) / 2 : e / 2;
    if (idx < 0) idx = 0;
    if (idx > 7) idx = 7;
    return w[7 - idx];
  endfunction

  assign miso_a = loop_a ? mosi_a : slave_bit(edges_a, cpha_a, slave_a);
  assign miso_b = mosi_b;

  // Monitor A
  logic       sck_prev_a;
  int         busy_cnt_a, rises_a;
  logic [7:0] mosi_w_a;
  logic [2:0] cs_or_a, cs_and_a;
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt_a = 0; rises_a = 0; edges_a = 0; mosi_w_a = '0;
      cs_or_a = '0; cs_and_a = '1;
    end else begin
      if (busy_a) begin
        if (busy_cnt_a > 0 && sck_a != sck_prev_a) begin
          edges_a++;
          if (sck_a) rises_a++;
          if (q_a.size() > 0 && ((edges_a % 2 == 1) ^ q_a[0].cpha))
            mosi_w_a = {mosi_w_a[6:0], mosi_a};
        end
        busy_cnt_a++;
        cs_or_a  = cs_or_a | csn_a;
        cs_and_a = cs_and_a & csn_a;
      end
      if (done_a) begin
        if (q_a.size() == 0) begin
          check("a_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q_a.pop_front();
          check("a_mdo", mdo_a, e.mdo);
          check("a_mosi_bits", mosi_w_a, e.mosi);
          check("a_busy_cycles", busy_cnt_a, e.cycles);
          check("a_sck_rises", rises_a, e.rises);
          check("a_cs_or", cs_or_a, e.csn);
          check("a_cs_and", cs_and_a, e.csn);
          check("a_sck_idle", sck_a, e.cpol);
          check("a_cs_release", csn_a, 3'b111);
        end
      end
      if (!busy_a) begin
        busy_cnt_a = 0; rises_a = 0; edges_a = 0; mosi_w_a = '0;
        cs_or_a = '0; cs_and_a = '1;
      end
    end
    sck_prev_a = sck_a;
  end

  // Monitor B (LSB first, so captured bits are assembled from the top down)
  logic        sck_prev_b;
  int          busy_cnt_b, rises_b, edges_b;
  logic [15:0] mosi_w_b;
  logic        cs_or_b, cs_and_b;
  always @(negedge clk) begin
    if (reset) begin
      busy_cnt_b = 0; rises_b = 0; edges_b = 0; mosi_w_b = '0;
      cs_or_b = 1'b0; cs_and_b = 1'b1;
    end else begin
      if (busy_b) begin
        if (busy_cnt_b > 0 && sck_b != sck_prev_b) begin
          edges_b++;
          if (sck_b) rises_b++;
          if (q_b.size() > 0 && ((edges_b % 2 == 1) ^ q_b[0].cpha))
            mosi_w_b = {mosi_b, mosi_w_b[15:1]};
        end
        busy_cnt_b++;
        cs_or_b  = cs_or_b | csn_b[0];
        cs_and_b = cs_and_b & csn_b[0];
      end
      if (done_b) begin
        if (q_b.size() == 0) begin
          check("b_unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q_b.pop_front();
          check("b_mdo", mdo_b, e.mdo);
          check("b_mosi_bits", mosi_w_b, e.mosi);
          check("b_busy_cycles", busy_cnt_b, e.cycles);
          check("b_sck_rises", rises_b, e.rises);
          check("b_cs_or", cs_or_b, e.csn[0]);
          check("b_cs_and", cs_and_b, e.csn[0]);
          check("b_sck_idle", sck_b, e.cpol);
          check("b_cs_release", csn_b, 1'b1);
        end
      end
      if (!busy_b) begin
        busy_cnt_b = 0; rises_b = 0; edges_b = 0; mosi_w_b = '0;
        cs_or_b = 1'b0; cs_and_b = 1'b1;
      end
    end
    sck_prev_b = sck_b;
  end

  task automatic go_a(input logic [7:0] mds, input logic pol, input logic pha,
                      input logic [1:0] sel, input logic lp, input logic [7:0] sw,
                      input logic [7:0] exp_mdo, input logic [2:0] exp_cs);
    exp_t e;
    mds_a = mds; cpol_a = pol; cpha_a = pha; sel_a = sel; loop_a = lp; slave_a = sw;
    e.mdo = {8'h00, exp_mdo}; e.mosi = {8'h00, mds}; e.csn = exp_cs;
    e.cpol = pol; e.cpha = pha; e.cycles = 36; e.rises = 8;
    q_a.push_back(e);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic go_b(input logic [15:0] mds, input logic pol, input logic pha,
                      input logic [15:0] exp_mdo);
    exp_t e;
    mds_b = mds; cpol_b = pol; cpha_b = pha; sel_b = 1'b0;
    e.mdo = exp_mdo; e.mosi = mds; e.csn = 3'b000;
    e.cpol = pol; e.cpha = pha; e.cycles = 34; e.rises = 16;
    q_b.push_back(e);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_a();
    for (int i = 0; i < 200; i++) begin
      if (q_a.size() == 0 && !busy_a) break;
      @(posedge clk); #1;
    end
    check("a_timeout_pending", q_a.size(), 0);
  endtask

  task automatic wait_b();
    for (int i = 0; i < 200; i++) begin
      if (q_b.size() == 0 && !busy_b) break;
      @(posedge clk); #1;
    end
    check("b_timeout_pending", q_b.size(), 0);
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_sck"},  sck_a,  1'b0);
    check({tag, "_mosi"}, mosi_a, 1'b0);
    check({tag, "_csn"},  csn_a,  3'b111);
    check({tag, "_mdo"},  mdo_a,  8'h00);
    check({tag, "_busy"}, busy_a, 1'b0);
    check({tag, "_done"}, done_a, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start_a = 0; cpol_a = 0; cpha_a = 0; sel_a = 0; mds_a = 0; loop_a = 1; slave_a = 0;
    start_b = 0; cpol_b = 0; cpha_b = 0; sel_b = 0; mds_b = 0;
    repeat (2) @(posedge clk); #1;
    check_reset_a("rst_idle_a");
    check("rst_idle_b_csn", csn_b, 1'b1);
    check("rst_idle_b_mdo", mdo_b, 16'h0000);
    reset = 1'b0;
    @(posedge clk); #1;

    // Mode 0 loopback, CS 0
    go_a(8'hA5, 0, 0, 2'd0, 1, 8'h00, 8'hA5, 3'b110);
    wait_a();
    repeat (3) @(posedge clk); #1;
    check("a_mdo_hold", mdo_a, 8'hA5);

    // Mode 3 with slave returning 3C, CS 2
    go_a(8'hC3, 1, 1, 2'd2, 0, 8'h3C, 8'h3C, 3'b011);
    wait_a();

    // Out-of-range CS plus an ignored start mid-transfer
    go_a(8'h5A, 0, 0, 2'd3, 1, 8'h00, 8'h5A, 3'b111);
    repeat (10) @(posedge clk); #1;
    mds_a = 8'hFF; sel_a = 2'd0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    check("a_busy_after_ignored_start", busy_a, 1'b1);
    wait_a();

    // Back-to-back: second start issued in the done cycle
    go_a(8'h96, 0, 1, 2'd1, 1, 8'h00, 8'h96, 3'b101);
    for (int i = 0; i < 100; i++) begin
      if (done_a) break;
      @(posedge clk); #1;
    end
    check("a_b2b_done_seen", done_a, 1'b1);
    go_a(8'h0F, 0, 1, 2'd1, 1, 8'h00, 8'h0F, 3'b101);
    check("a_b2b_busy", busy_a, 1'b1);
    wait_a();

    // Reset 10 cycles into a mode-1 transfer, then a clean transfer
    go_a(8'hE7, 0, 1, 2'd0, 1, 8'h00, 8'hE7, 3'b110);
    repeat (9) @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_reset_a("rst_mid_a");
    q_a.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (40) @(posedge clk); #1;
    check("a_no_done_after_abort", mdo_a, 8'h00);
    go_a(8'h3C, 0, 1, 2'd0, 1, 8'h00, 8'h3C, 3'b110);
    wait_a();

    // LSB first, W16, DIV1
    go_b(16'h8001, 0, 0, 16'h8001);
    wait_b();
    go_b(16'h1234, 1, 0, 16'h1234);
    wait_b();

    // Random stimulus on A, then reset before any transfer could finish
    for (int i = 0; i < 6; i++) begin
      start_a = 1'($urandom_range(0, 1));
      mds_a   = 8'($urandom);
      cpol_a  = 1'($urandom_range(0, 1));
      cpha_a  = 1'($urandom_range(0, 1));
      sel_a   = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    reset = 1'b1;
    start_a = 1'b0; cpol_a = 1'b0;
    #1;
    check_reset_a("rst_random_a");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
